// File: rtl/abs_sum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : abs_sum_pkg
// Purpose  : Shared FSM state encoding and constant helpers for abs_sum_accum.
// Revision : 1.0
// ============================================================================
package abs_sum_pkg;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r_bits;
        int v;
        r_bits = 0;
        v      = value - 1;
        while (v > 0) begin
            r_bits = r_bits + 1;
            v      = v >> 1;
        end
        return r_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/abs_sum_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : abs_sum_accum_if
// Purpose  : Sample-in / result-out handshake bundle for abs_sum_accum.
// Revision : 1.0
// ============================================================================
interface abs_sum_accum_if #(
    parameter int W  = 4,
    parameter int OW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_abs;
    logic          out_neg;
    logic          out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_abs, out_neg, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_abs, out_neg, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/abs_sat.sv
`default_nettype none
// ============================================================================
// Module   : abs_sat
// Purpose  : Signed AW-bit value to OW-bit saturated magnitude, sign, overflow.
// Revision : 1.0
// ============================================================================
module abs_sat #(
    parameter int AW = 6,
    parameter int OW = 4
) (
    input  wire logic signed [AW-1:0] i_value,
    output logic             [OW-1:0] o_abs,
    output logic                      o_neg,
    output logic                      o_ovf
);
    logic [AW-1:0] w_mag;

    // Negating the most negative value wraps to 2^(AW-1), which is the
    // correct unsigned magnitude, so no extra guard bit is needed.
    assign o_neg = i_value[AW-1];
    assign w_mag = o_neg ? (~i_value + AW'(1)) : i_value;

    generate
        if (OW >= AW) begin : g_wide
            assign o_ovf = 1'b0;
            assign o_abs = OW'(w_mag);
        end else begin : g_narrow
            assign o_ovf = |w_mag[AW-1:OW];
            assign o_abs = o_ovf ? {OW{1'b1}} : w_mag[OW-1:0];
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/abs_sum_accum.sv
`default_nettype none
// ============================================================================
// Module   : abs_sum_accum
// Purpose  : Accumulates N signed samples per frame and returns the saturated
//            magnitude of the sum with sign and overflow flags.
// Revision : 1.0
// ============================================================================
module abs_sum_accum
    import abs_sum_pkg::*;
#(
    parameter int W  = 4,
    parameter int N  = 4,
    parameter int OW = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    abs_sum_accum_if.slave bus
);
    localparam int C_CW = clog2(N);
    localparam int C_AW = W + C_CW;

    state_t                   r_state;
    logic signed [C_AW-1:0]   r_acc;
    logic        [C_CW-1:0]   r_cnt;
    logic        [OW-1:0]     r_abs;
    logic                     r_neg;
    logic                     r_ovf;

    logic signed [C_AW-1:0]   w_sample;
    logic signed [C_AW-1:0]   w_final;
    logic        [OW-1:0]     w_abs;
    logic                     w_neg;
    logic                     w_ovf;
    logic                     w_last;

    assign w_sample = {{C_CW{bus.in_data[W-1]}}, bus.in_data};
    assign w_final  = r_acc + w_sample;
    assign w_last   = (r_cnt == C_CW'(N - 1));

    abs_sat #(
        .AW (C_AW),
        .OW (OW)
    ) u_abs_sat (
        .i_value (w_final),
        .o_abs   (w_abs),
        .o_neg   (w_neg),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_abs   <= '0;
            r_neg   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (clr) begin
            r_state <= ST_ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (bus.in_valid) begin
                        if (w_last) begin
                            r_abs   <= w_abs;
                            r_neg   <= w_neg;
                            r_ovf   <= w_ovf;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_acc <= w_final;
                            r_cnt <= r_cnt + C_CW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    // Handshake flags come straight off the state register.
    assign bus.in_ready  = (r_state == ST_ACC);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_abs   = r_abs;
    assign bus.out_neg   = r_neg;
    assign bus.out_ovf   = r_ovf;
endmodule
`default_nettype wire
